pipe_stall_ctrl: RTL and testbench

Generates the pipeline interlock signals consumed by the `stall`-gated PC and IF/ID pipeline registers and by the ID/EX bubble-insertion logic.
- Detects load-use hazards between the ID and EX stages.
- Sequences multi-cycle multiply/divide occupancy with an internal countdown FSM, holding the front end until the operation completes.
- Sits beside the ID stage of the 5-stage pipelined CPU.

---
 rtl/pipe_stall_ctrl_pkg.sv | 13 +
 rtl/mdu_countdown.sv | 30 +++
 rtl/pipe_stall_ctrl.sv | 113 +++++++++++
 tb/tb_pipe_stall_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared constants and state encoding for the ID-stage interlock logic.
package pipe_stall_ctrl_pkg;

    localparam int REG_W          = 5;
    localparam int DEF_MUL_CYCLES = 4;
    localparam int DEF_DIV_CYCLES = 32;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mdu_state_t;

endpackage

// File: rtl/mdu_countdown.sv
// Down-counter tracking the remaining occupancy cycles of a multiply/divide.
module mdu_countdown #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             zero
);

    // Clear has priority over load; decrement saturates at zero so it never wraps.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/pipe_stall_ctrl.sv
// ID-stage interlock: load-use hazard detection plus multiply/divide occupancy
// sequencing. stall/bubble are combinational so a hazard holds the front end in
// the same cycle it is seen.
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = DEF_MUL_CYCLES,
    parameter int DIV_CYCLES = DEF_DIV_CYCLES,
    parameter int CNT_W      = 6
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_mdu,
    input  logic             id_div,
    input  logic             ex_m2reg,
    input  logic             ex_wreg,
    input  logic [REG_W-1:0] ex_rn,
    input  logic             flush,
    output logic             stall,
    output logic             bubble,
    output logic             mdu_busy,
    output logic             mdu_done
);

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    mdu_state_t       state;
    mdu_state_t       next_state;
    logic             lu;
    logic             stall_c;
    logic             done_c;
    logic             cnt_load;
    logic             cnt_dec;
    logic             cnt_clr;
    logic [CNT_W-1:0] cnt;
    logic             cnt_zero;

    // Register 0 is hardwired, so a load targeting it can never create a hazard.
    assign lu = ex_m2reg & ex_wreg & (ex_rn != '0) &
                ((id_use_rs & (id_rs == ex_rn)) | (id_use_rt & (id_rt == ex_rn)));

    // Next-state and interlock decode; the issue cycle itself counts as the
    // first stall cycle, so the counter is loaded with the total minus one.
    always_comb begin
        next_state = state;
        stall_c    = 1'b0;
        done_c     = 1'b0;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        cnt_clr    = 1'b0;
        case (state)
            IDLE: begin
                if (flush) begin
                    next_state = IDLE;
                end else if (lu) begin
                    stall_c = 1'b1;
                end else if (id_mdu) begin
                    stall_c    = 1'b1;
                    cnt_load   = 1'b1;
                    next_state = BUSY;
                end
            end
            BUSY: begin
                if (flush) begin
                    cnt_clr    = 1'b1;
                    next_state = IDLE;
                end else if (!cnt_zero) begin
                    stall_c = 1'b1;
                    cnt_dec = 1'b1;
                end else begin
                    done_c     = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // State register; a zero load value lands in BUSY with cnt==0, which is the
    // final cycle of the operation.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    mdu_countdown #(
        .CNT_W (CNT_W)
    ) u_countdown (
        .clk      (clk),
        .clrn     (clrn),
        .load     (cnt_load),
        .load_val (id_div ? DIV_LOAD : MUL_LOAD),
        .dec      (cnt_dec),
        .clr      (cnt_clr),
        .cnt      (cnt),
        .zero     (cnt_zero)
    );

    // Gate with clrn so a live hazard on the inputs cannot stall during reset.
    assign stall    = stall_c & clrn;
    assign bubble   = stall_c & clrn;
    assign mdu_busy = (state == BUSY);
    assign mdu_done = done_c & clrn;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl: a driver pushes the expected per-cycle
// outputs from a cycle-count model; a negedge monitor pops and compares.
module tb_pipe_stall_ctrl;

    localparam int MUL_N = 4;
    localparam int DIV_N = 32;

    logic       clk = 1'b0;
    logic       clrn = 1'b0;
    logic [4:0] id_rs = '0, id_rt = '0, ex_rn = '0;
    logic       id_use_rs = 0, id_use_rt = 0, id_mdu = 0, id_div = 0;
    logic       ex_m2reg = 0, ex_wreg = 0, flush = 0;
    logic       stall, bubble, mdu_busy, mdu_done;

    int tests = 0;
    int fails = 0;
    int mon_cyc = 0;

    logic [3:0] exp_q[$];

    // Model state: an operation in flight, its length, and cycles since issue.
    bit m_in_op = 0;
    int m_el    = 0;
    int m_len   = 0;

    pipe_stall_ctrl #(
        .MUL_CYCLES (MUL_N),
        .DIV_CYCLES (DIV_N),
        .CNT_W      (6)
    ) dut (
        .clk       (clk),
        .clrn      (clrn),
        .id_rs     (id_rs),
        .id_rt     (id_rt),
        .id_use_rs (id_use_rs),
        .id_use_rt (id_use_rt),
        .id_mdu    (id_mdu),
        .id_div    (id_div),
        .ex_m2reg  (ex_m2reg),
        .ex_wreg   (ex_wreg),
        .ex_rn     (ex_rn),
        .flush     (flush),
        .stall     (stall),
        .bubble    (bubble),
        .mdu_busy  (mdu_busy),
        .mdu_done  (mdu_done)
    );

    always #5 clk = ~clk;

    // Monitor: compare {stall,bubble,mdu_busy,mdu_done} once per driven cycle.
    always @(negedge clk) begin
        logic [3:0] e;
        logic [3:0] act;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            act = {stall, bubble, mdu_busy, mdu_done};
            tests++;
            mon_cyc++;
            if (act !== e) begin
                fails++;
                $display("FAIL cycle_outputs cyc=%0d {stall,bubble,busy,done} got=%b expected=%b",
                         mon_cyc, act, e);
            end
        end
    end

    task automatic chk_zero(input string name);
        logic [3:0] act;
        act = {stall, bubble, mdu_busy, mdu_done};
        tests++;
        if (act !== 4'b0000) begin
            fails++;
            $display("FAIL %s {stall,bubble,busy,done} got=%b expected=0000", name, act);
        end
    endtask

    // Drive one cycle of ID/EX inputs and push the expected outputs.
    task automatic cyc(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                       input logic urt, input logic mdu, input logic dv, input logic m2,
                       input logic wr, input logic [4:0] rn, input logic fl);
        logic [3:0] e;
        bit lu;
        @(posedge clk);
        #1;
        id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
        id_mdu = mdu; id_div = dv; ex_m2reg = m2; ex_wreg = wr; ex_rn = rn; flush = fl;
        lu = m2 && wr && (rn != 0) && ((urs && rs == rn) || (urt && rt == rn));
        if (!m_in_op) begin
            if (fl)       e = 4'b0000;
            else if (lu)  e = 4'b1100;
            else if (mdu) begin
                e = 4'b1100;
                m_in_op = 1;
                m_el = 0;
                m_len = dv ? DIV_N : MUL_N;
            end
            else          e = 4'b0000;
        end else begin
            if (fl) begin
                e = 4'b0010;
                m_in_op = 0;
            end else if (m_el < m_len) begin
                e = 4'b1110;
            end else begin
                e = 4'b0011;
                m_in_op = 0;
            end
        end
        if (m_in_op) m_el++;
        exp_q.push_back(e);
    endtask

    task automatic idle_cyc();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic clear_inputs();
        id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0; id_mdu = 0; id_div = 0;
        ex_m2reg = 0; ex_wreg = 0; ex_rn = 0; flush = 0;
    endtask

    initial begin
        // Reset with a live load-use hazard and MDU request on the inputs.
        id_rs = 5; id_use_rs = 1; ex_m2reg = 1; ex_wreg = 1; ex_rn = 5; id_mdu = 1;
        #3 chk_zero("reset_hold_a");
        #8 chk_zero("reset_hold_b");
        clear_inputs();
        #3 clrn = 1'b1;

        // Load-use via rs, then load drains.
        cyc(5, 0, 1, 0, 0, 0, 1, 1, 5, 0);
        idle_cyc();
        // Same with ex_rn=0: no hazard.
        cyc(0, 0, 1, 0, 0, 0, 1, 1, 0, 0);
        // Load-use via rt; rs match without use flag must not count.
        cyc(7, 9, 0, 1, 0, 0, 1, 1, 9, 0);
        cyc(9, 3, 0, 1, 0, 0, 1, 1, 9, 0);
        // Load without register write: no hazard.
        cyc(5, 0, 1, 0, 0, 0, 1, 0, 5, 0);
        idle_cyc();

        // Multiply: held for issue + 3 busy + done, then next instruction.
        repeat (MUL_N + 1) cyc(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        idle_cyc();
        // Divide.
        repeat (DIV_N + 1) cyc(0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        idle_cyc();
        // Load-use together with a multiply, then the multiply sequence.
        cyc(4, 0, 1, 0, 1, 0, 1, 1, 4, 0);
        repeat (MUL_N + 1) cyc(4, 0, 1, 0, 1, 0, 0, 0, 0, 0);
        idle_cyc();
        // Back-to-back multiplies.
        repeat (2 * (MUL_N + 1)) cyc(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        idle_cyc();
        // Flush in the 3rd BUSY cycle of a divide.
        repeat (3) cyc(0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 1, 0, 0, 0, 1);
        idle_cyc();
        idle_cyc();
        // Flush in IDLE overrides a load-use hazard and an MDU request.
        cyc(6, 0, 1, 0, 1, 0, 1, 1, 6, 1);
        idle_cyc();

        // Asynchronous reset mid-divide, between clock edges.
        repeat (6) cyc(0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        @(negedge clk);
        #2 clrn = 1'b0;
        #1 chk_zero("reset_mid_divide");
        clear_inputs();
        @(posedge clk);
        #1 chk_zero("reset_mid_hold");
        @(negedge clk);
        #2 clrn = 1'b1;
        m_in_op = 0;
        #1 chk_zero("reset_release");
        // A fresh multiply after reset must take exactly MUL_N stall cycles.
        repeat (MUL_N + 1) cyc(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        idle_cyc();

        // Randomized traffic over a small register set so hazards are frequent.
        for (int i = 0; i < 3000; i++) begin
            cyc(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 2) == 0),
                1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 3) != 0),
                5'($urandom_range(0, 3)), 1'($urandom_range(0, 29) == 0));
        end

        @(negedge clk);
        #1;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain left=%0d expected=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
